// File: rtl/ram_access_scheduler_pkg.sv
// ram_access_scheduler_pkg
// Shared definitions for the RAM access scheduler and its port multiplexer.
// Holds the default RAM geometry (also used by the IO side) and the job
// phase encoding, which is visible externally on the Phase output.
package ram_access_scheduler_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 13;
    localparam int DATA_WIDTH_DEFAULT    = 64;

    // Job phases. The numeric values are architectural: they appear on Phase.
    // TURN_LS and TURN_SS are the dead turnaround cycles between RAM owners.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        TURN_LS = 3'd2,
        SOLVE   = 3'd3,
        TURN_SS = 3'd4,
        SEND    = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/ram_access_scheduler_ram_port_mux.sv
// ram_port_mux
// Purely combinational selector that hands the shared RAM ports (one write,
// two read) to whichever requester owns them in the current phase.
// Ports:
//   i_state                      registered job phase
//   i_io_*                       loader write port and sender read addresses
//   i_solver_*                   solver write port and read addresses
//   o_ram_*                      muxed RAM write port and read addresses
module ram_port_mux
    import ram_access_scheduler_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
    input  state_t                   i_state,
    input  logic                     i_io_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] i_io_addr_wr,
    input  logic [DATA_WIDTH-1:0]    i_io_data_wr,
    input  logic [ADDRESS_WIDTH-1:0] i_io_addr_rd_a,
    input  logic [ADDRESS_WIDTH-1:0] i_io_addr_rd_b,
    input  logic                     i_solver_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] i_solver_addr_wr,
    input  logic [DATA_WIDTH-1:0]    i_solver_data_wr,
    input  logic [ADDRESS_WIDTH-1:0] i_solver_addr_rd_a,
    input  logic [ADDRESS_WIDTH-1:0] i_solver_addr_rd_b,
    output logic                     o_ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr_wr,
    output logic [DATA_WIDTH-1:0]    o_ram_data_wr,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr_rd_a,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr_rd_b
);

    // Everything defaults to zero so that a non-owner's write enable can never
    // reach the RAM; turnaround, idle and done phases drive an all-zero bus.
    always_comb begin
        o_ram_wr_en     = 1'b0;
        o_ram_addr_wr   = '0;
        o_ram_data_wr   = '0;
        o_ram_addr_rd_a = '0;
        o_ram_addr_rd_b = '0;
        case (i_state)
            LOAD: begin
                o_ram_wr_en   = i_io_wr_en;
                o_ram_addr_wr = i_io_addr_wr;
                o_ram_data_wr = i_io_data_wr;
            end
            SOLVE: begin
                o_ram_wr_en     = i_solver_wr_en;
                o_ram_addr_wr   = i_solver_addr_wr;
                o_ram_data_wr   = i_solver_data_wr;
                o_ram_addr_rd_a = i_solver_addr_rd_a;
                o_ram_addr_rd_b = i_solver_addr_rd_b;
            end
            SEND: begin
                o_ram_addr_rd_a = i_io_addr_rd_a;
                o_ram_addr_rd_b = i_io_addr_rd_b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_access_scheduler.sv
// ram_access_scheduler
// Sequences one ODE job through load, solve and send, owns the shared RAM
// ports and raises the job-level handshakes.
// Ports:
//   CLK, RST                      clock (rising edge), async active-low reset
//   Load_Process                  job request level; dropping it aborts a job
//   Done_Loading/Solver_Done/
//   Done_Sending                  per-phase completion inputs
//   IO_*, Solver_*                requester-side RAM ports
//   RAM_*                         muxed RAM ports
//   Solver_Start                  one-cycle pulse during TURN_LS
//   Sending_Enable                high throughout SEND
//   Done_Processing               high throughout DONE
//   Timeout_Error                 sticky until the next job enters LOAD
//   Phase                         current phase encoding
module ram_access_scheduler
    import ram_access_scheduler_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEFAULT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Load_Process,
    input  logic                     Done_Loading,
    input  logic                     Solver_Done,
    input  logic                     Done_Sending,
    input  logic                     IO_WR_Enable,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_WR,
    input  logic [DATA_WIDTH-1:0]    IO_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_B,
    input  logic                     Solver_WR_Enable,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_WR,
    input  logic [DATA_WIDTH-1:0]    Solver_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_B,
    output logic                     RAM_WR_Enable,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
    output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
    output logic                     Solver_Start,
    output logic                     Sending_Enable,
    output logic                     Done_Processing,
    output logic                     Timeout_Error,
    output logic [2:0]               Phase
);

    // Counter value seen during the last permitted cycle of an active phase.
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_timeoutError;
    logic                   w_active;
    logic                   w_phaseDone;
    logic                   w_timeout;

    // Phase register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-phase logic. Abort has the last word so that dropping the job
    // request never raises an error, and a done input on the final permitted
    // cycle beats the timeout because the timeout only fires when done is low.
    always_comb begin
        w_nextState = r_state;
        w_active    = 1'b0;
        w_phaseDone = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE:    if (Load_Process) w_nextState = LOAD;
            LOAD: begin
                w_active    = 1'b1;
                w_phaseDone = Done_Loading;
                if (Done_Loading) w_nextState = TURN_LS;
            end
            TURN_LS: w_nextState = SOLVE;
            SOLVE: begin
                w_active    = 1'b1;
                w_phaseDone = Solver_Done;
                if (Solver_Done) w_nextState = TURN_SS;
            end
            TURN_SS: w_nextState = SEND;
            SEND: begin
                w_active    = 1'b1;
                w_phaseDone = Done_Sending;
                if (Done_Sending) w_nextState = DONE;
            end
            DONE:    if (!Load_Process) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (w_active && !w_phaseDone && (r_count == LAST_COUNT)) begin
            w_nextState = IDLE;
            w_timeout   = 1'b1;
        end
        if (!Load_Process && (r_state != IDLE) && (r_state != DONE)) begin
            w_nextState = IDLE;
            w_timeout   = 1'b0;
        end
    end

    // Cycles spent in the current phase; restarts on every phase change and
    // only advances while a requester is doing work.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (w_nextState != r_state) begin
            r_count <= '0;
        end else if (w_active) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    // Sticky timeout flag, cleared only when a fresh job starts loading.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_timeoutError <= 1'b0;
        end else if (w_timeout) begin
            r_timeoutError <= 1'b1;
        end else if ((r_state == IDLE) && (w_nextState == LOAD)) begin
            r_timeoutError <= 1'b0;
        end
    end

    ram_port_mux #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram_port_mux (
        .i_state            (r_state),
        .i_io_wr_en         (IO_WR_Enable),
        .i_io_addr_wr       (IO_Address_WR),
        .i_io_data_wr       (IO_Data_WR),
        .i_io_addr_rd_a     (IO_Address_RD_A),
        .i_io_addr_rd_b     (IO_Address_RD_B),
        .i_solver_wr_en     (Solver_WR_Enable),
        .i_solver_addr_wr   (Solver_Address_WR),
        .i_solver_data_wr   (Solver_Data_WR),
        .i_solver_addr_rd_a (Solver_Address_RD_A),
        .i_solver_addr_rd_b (Solver_Address_RD_B),
        .o_ram_wr_en        (RAM_WR_Enable),
        .o_ram_addr_wr      (RAM_Address_WR),
        .o_ram_data_wr      (RAM_Data_WR),
        .o_ram_addr_rd_a    (RAM_Address_RD_A),
        .o_ram_addr_rd_b    (RAM_Address_RD_B)
    );

    assign Solver_Start    = (r_state == TURN_LS);
    assign Sending_Enable  = (r_state == SEND);
    assign Done_Processing = (r_state == DONE);
    assign Timeout_Error   = r_timeoutError;
    assign Phase           = r_state;

endmodule

// File: doc/ram_access_scheduler.md
Name: ram_access_scheduler

Overview:
- Sequences one ODE job through three phases: load, solve, send.
- Owns the shared RAM ports: one write port and two read ports.
- Multiplexes the RAM ports between the IO loader/sender and the solver core, with a dead turnaround cycle between owners.
- Raises the job-level handshakes: solver start, sender enable, processing done, timeout.

Parameters:
- ADDRESS_WIDTH, 13, RAM address width.
- DATA_WIDTH, 64, RAM word width.
- TIMEOUT_CYCLES, 65535, maximum cycles allowed in any one active phase (LOAD, SOLVE, SEND).
- CNT_WIDTH, 16, timeout counter width; must satisfy 2^CNT_WIDTH >= TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- Load_Process  in  1  job request level from the CPU side.
- Done_Loading  in  1  loader finished (pulse or level).
- Solver_Done  in  1  solver finished (pulse or level).
- Done_Sending  in  1  sender finished (pulse or level).
- IO_WR_Enable  in  1  loader write enable.
- IO_Address_WR  in  ADDRESS_WIDTH  loader write address.
- IO_Data_WR  in  DATA_WIDTH  loader write data.
- IO_Address_RD_A  in  ADDRESS_WIDTH  sender read address, port A.
- IO_Address_RD_B  in  ADDRESS_WIDTH  sender read address, port B.
- Solver_WR_Enable  in  1  solver write enable.
- Solver_Address_WR  in  ADDRESS_WIDTH  solver write address.
- Solver_Data_WR  in  DATA_WIDTH  solver write data.
- Solver_Address_RD_A  in  ADDRESS_WIDTH  solver read address, port A.
- Solver_Address_RD_B  in  ADDRESS_WIDTH  solver read address, port B.
- RAM_WR_Enable  out  1  muxed RAM write enable.
- RAM_Address_WR  out  ADDRESS_WIDTH  muxed RAM write address.
- RAM_Data_WR  out  DATA_WIDTH  muxed RAM write data.
- RAM_Address_RD_A  out  ADDRESS_WIDTH  muxed RAM read address, port A.
- RAM_Address_RD_B  out  ADDRESS_WIDTH  muxed RAM read address, port B.
- Solver_Start  out  1  one-cycle solver start pulse.
- Sending_Enable  out  1  sender enable level.
- Done_Processing  out  1  job complete level.
- Timeout_Error  out  1  sticky phase-timeout flag.
- Phase  out  3  current state encoding.

Behaviour:
- Reset: RST low, asynchronously, forces state IDLE, counter 0, Timeout_Error 0. Every output is 0 while RST is low and in IDLE.
- States and encodings: IDLE=0, LOAD=1, TURN_LS=2, SOLVE=3, TURN_SS=4, SEND=5, DONE=6. Encoding 7 is illegal and goes to IDLE on the next cycle.
- IDLE -> LOAD when Load_Process=1. Entering LOAD clears Timeout_Error.
- LOAD -> TURN_LS when Done_Loading=1.
- TURN_LS -> SOLVE unconditionally after 1 cycle.
- SOLVE -> TURN_SS when Solver_Done=1.
- TURN_SS -> SEND unconditionally after 1 cycle.
- SEND -> DONE when Done_Sending=1.
- DONE -> IDLE when Load_Process=0.
- Abort: Load_Process=0 in any state other than IDLE or DONE gives IDLE on the next edge. No done or error flag is raised.
- Port mux is combinational from the registered state; zero latency from requester to RAM:
  - LOAD: write port = IO_*; read ports = 0.
  - SOLVE: all ports = Solver_*.
  - SEND: read ports = IO_Address_RD_*; RAM_WR_Enable=0; write address and data = 0.
  - Every other state: all RAM outputs 0.
  - Write enables of non-owners are ignored.
- Solver_Start = 1 exactly during TURN_LS, giving a single pulse.
- Sending_Enable = 1 throughout SEND.
- Done_Processing = 1 throughout DONE.
- Phase = state encoding.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle in LOAD, SOLVE and SEND.
  - If the counter equals TIMEOUT_CYCLES-1 and the phase's done input is 0: set Timeout_Error and go to IDLE.
  - A done input in that same cycle wins: normal transition, no error.
- A done input arriving outside its phase is ignored.
- Done inputs held high are harmless: each is sampled only in its own phase.

Decomposition:
- Shared package holds:
  - state localparams IDLE..DONE, 3-bit;
  - the ADDRESS_WIDTH and DATA_WIDTH defaults, shared with the IO module.
- One natural sub-module, ram_port_mux: purely combinational; selects on state; contains the write-enable gating.
- FSM and timeout counter stay in the top.

Test Plan:
- Full job, TIMEOUT_CYCLES=100:
  - Load_Process=1 -> Phase=1 next cycle.
  - IO_WR_Enable=1, IO_Address_WR=0x005, IO_Data_WR=0xA5 -> RAM mirrors the same cycle.
  - Done_Loading -> Phase=2 with Solver_Start=1 for 1 cycle, then Phase=3.
  - Solver_Done -> Phase 4 then Phase 5 with Sending_Enable=1.
  - Done_Sending -> Done_Processing=1.
  - Load_Process=0 -> Phase=0.
- Isolation:
  - In SOLVE, IO_WR_Enable=1 -> RAM_WR_Enable follows Solver_WR_Enable only.
  - In SEND, Solver_WR_Enable=1 -> RAM_WR_Enable=0.
  - In TURN_LS and TURN_SS, all RAM outputs are 0.
- Timeout, TIMEOUT_CYCLES=8:
  - Solver_Done never asserted -> 8th SOLVE cycle gives Timeout_Error=1 and Phase=0.
  - Next Load_Process=1 -> Timeout_Error=0 in LOAD.
- Tie, TIMEOUT_CYCLES=8: Done_Loading on the 8th LOAD cycle -> Phase=2, Timeout_Error stays 0.
- Abort: Load_Process dropped mid-SOLVE -> Phase=0 next cycle, Done_Processing=0, RAM_WR_Enable=0.
- Async reset: RST low mid-SEND, between clock edges -> outputs 0 immediately. RST high -> stays IDLE until Load_Process=1.
